// File: rtl/hyperram_arb_pkg.sv
// Shared types and constants for the two-port HyperRAM arbiter.
package hyperram_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    // Read data returned to the owner when the controller never answers.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/hyperram_arbiter.sv
// Two-port round-robin arbiter in front of the HyperRAM controller port.
// Ports:
//   clk, nreset                      clock, async active-low reset
//   m0_*/m1_* valid,addr,wdata,wstrb  master requests (wstrb==0 is a read)
//   m0_ready/m1_ready, m0/m1_rdata   one-cycle completion pulse, shared read data
//   s_valid,s_addr,s_wdata,s_wstrb   registered request to the controller
//   s_ready, s_rdata                 controller completion and read data
//   grant                            last or current owner
//   timeout                          sticky controller timeout flag
module hyperram_arbiter
    import hyperram_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS      = 21,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 m0_valid,
    input  logic [ADDR_BITS-1:0] m0_addr,
    input  logic [31:0]          m0_wdata,
    input  logic [3:0]           m0_wstrb,
    output logic                 m0_ready,
    output logic [31:0]          m0_rdata,
    input  logic                 m1_valid,
    input  logic [ADDR_BITS-1:0] m1_addr,
    input  logic [31:0]          m1_wdata,
    input  logic [3:0]           m1_wstrb,
    output logic                 m1_ready,
    output logic [31:0]          m1_rdata,
    output logic                 s_valid,
    output logic [ADDR_BITS-1:0] s_addr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wstrb,
    input  logic [31:0]          s_rdata,
    input  logic                 s_ready,
    output logic                 grant,
    output logic                 timeout
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_q;

    logic                 win_c;
    logic [ADDR_BITS-1:0] win_addr_c;
    logic [31:0]          win_wdata_c;
    logic [3:0]           win_wstrb_c;

    // Tie goes to the port that did not own the previous transaction.
    always_comb begin
        win_c = m1_valid;
        if (m0_valid && m1_valid) begin
            win_c = ~last;
        end
        win_addr_c  = win_c ? m1_addr  : m0_addr;
        win_wdata_c = win_c ? m1_wdata : m0_wdata;
        win_wstrb_c = win_c ? m1_wstrb : m0_wstrb;
    end

    // Both masters see the same response register; only the owner's ready qualifies it.
    assign m0_rdata = rdata_q;
    assign m1_rdata = rdata_q;

    // Transaction sequencer with registered downstream request and responses.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= ST_IDLE;
            last     <= 1'b1;
            cnt      <= '0;
            rdata_q  <= '0;
            s_valid  <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            grant    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (m0_valid || m1_valid) begin
                        s_addr  <= win_addr_c;
                        s_wdata <= win_wdata_c;
                        s_wstrb <= win_wstrb_c;
                        s_valid <= 1'b1;
                        grant   <= win_c;
                        cnt     <= '0;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A late s_ready coinciding with the timeout still counts as success.
                    if (s_ready || (cnt == CNT_LAST)) begin
                        rdata_q  <= s_ready ? s_rdata : TIMEOUT_RDATA;
                        if (!s_ready) begin
                            timeout <= 1'b1;
                        end
                        s_valid  <= 1'b0;
                        m0_ready <= ~grant;
                        m1_ready <= grant;
                        last     <= grant;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // Ignore valids here so the just-served request is not taken twice.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperram_arbiter.sv
// Self-checking bench for hyperram_arbiter: directed scenarios plus random
// traffic, checked against a transaction-level model of the arbitration rules.
module tb_hyperram_arbiter;

    localparam int unsigned AW = 21;
    localparam int unsigned T  = 16;

    logic          clk = 1'b0;
    logic          nreset;
    logic          m0_valid, m1_valid;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic [3:0]    m0_wstrb, m1_wstrb;
    logic          m0_ready, m1_ready;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          s_valid;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic [31:0]   s_rdata;
    logic          s_ready;
    logic          grant, timeout;

    hyperram_arbiter #(.ADDR_BITS(AW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .nreset(nreset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Master-side state.
    bit            v[2];
    logic [AW-1:0] addr[2];
    logic [31:0]   wdata[2];
    logic [3:0]    wstrb[2];
    int            served[2];
    int            mst_mode = 2;   // 0 random, 1 continuous with budget, 2 no new requests
    int            budget   = 0;

    // Controller-side state: lat_mode <0 random 1..20, 0 never answers, >0 fixed.
    int          lat_mode    = 5;
    int          tgt         = -1;
    bit          rdata_fix_en = 0;
    logic [31:0] rdata_fix   = '0;

    // Reference model state.
    int cyc       = 0;
    bit busy_m    = 0;
    int start_cyc = 0;
    int free_at   = 0;
    bit own       = 0;
    bit ref_last  = 1;
    bit ref_to    = 0;
    int grant_log[$];

    task automatic apply();
        m0_valid = v[0]; m0_addr = addr[0]; m0_wdata = wdata[0]; m0_wstrb = wstrb[0];
        m1_valid = v[1]; m1_addr = addr[1]; m1_wdata = wdata[1]; m1_wstrb = wstrb[1];
    endtask

    task automatic new_req(input int i);
        v[i]     = 1;
        addr[i]  = AW'($urandom);
        wdata[i] = $urandom;
        wstrb[i] = ($urandom_range(2, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
    endtask

    // Predict one clock edge from the valids/ready that were presented before it.
    task automatic model(input bit pv0, input bit pv1, input bit psr, input logic [31:0] psd);
        bit          exp_r[2];
        bit          done;
        logic [31:0] exp_d;
        exp_r[0] = 0; exp_r[1] = 0; done = 0; exp_d = '0;
        if (!busy_m) begin
            if (cyc >= free_at && (pv0 || pv1)) begin
                own = (pv0 && pv1) ? !ref_last : pv1;
                busy_m = 1; start_cyc = cyc;
                grant_log.push_back(int'(own));
                check_eq("start_s_valid", 64'(s_valid), 64'(1));
                check_eq("start_grant", 64'(grant), 64'(own));
                check_eq("start_s_addr", 64'(s_addr), 64'(addr[own]));
                check_eq("start_s_wdata", 64'(s_wdata), 64'(wdata[own]));
                check_eq("start_s_wstrb", 64'(s_wstrb), 64'(wstrb[own]));
            end else begin
                check_eq("idle_s_valid", 64'(s_valid), 64'(0));
            end
        end else begin
            if (psr) begin
                done = 1; exp_d = psd;
            end else if (cyc - start_cyc == int'(T)) begin
                done = 1; exp_d = 32'hFFFF_FFFF; ref_to = 1;
            end
            if (done) begin
                exp_r[own] = 1; busy_m = 0; free_at = cyc + 2; ref_last = own;
                check_eq("end_s_valid", 64'(s_valid), 64'(0));
                check_eq("m0_rdata", 64'(m0_rdata), 64'(exp_d));
                check_eq("m1_rdata", 64'(m1_rdata), 64'(exp_d));
            end else begin
                check_eq("busy_s_valid", 64'(s_valid), 64'(1));
                check_eq("busy_s_addr", 64'(s_addr), 64'(addr[own]));
            end
        end
        check_eq("m0_ready", 64'(m0_ready), 64'(exp_r[0]));
        check_eq("m1_ready", 64'(m1_ready), 64'(exp_r[1]));
        check_eq("timeout", 64'(timeout), 64'(ref_to));
    endtask

    // React to the outputs just sampled: controller first, then masters.
    task automatic drive();
        bit rdy;
        if (!s_valid) begin
            tgt = -1; s_ready = 0;
        end else begin
            if (tgt < 0) begin
                if (lat_mode < 0)       tgt = cyc + int'($urandom_range(20, 1));
                else if (lat_mode == 0) tgt = cyc + 1000000;
                else                    tgt = cyc + lat_mode;
            end
            s_ready = (cyc + 1 == tgt);
            s_rdata = rdata_fix_en ? rdata_fix : $urandom;
        end
        for (int i = 0; i < 2; i++) begin
            rdy = (i == 0) ? m0_ready : m1_ready;
            if (rdy && v[i]) begin
                served[i]++; v[i] = 0;
                if (mst_mode == 1 && budget > 0) begin
                    budget--; new_req(i);
                end else if (mst_mode == 0 && $urandom_range(1, 0) == 1) begin
                    new_req(i);
                end
            end else if (!v[i] && mst_mode == 0 && $urandom_range(3, 0) == 0) begin
                new_req(i);
            end
        end
        apply();
    endtask

    task automatic step();
        bit          pv0, pv1, psr;
        logic [31:0] psd;
        pv0 = m0_valid; pv1 = m1_valid; psr = s_ready; psd = s_rdata;
        @(posedge clk); #1;
        cyc++;
        model(pv0, pv1, psr, psd);
        drive();
    endtask

    task automatic wait_served(input int target, input int limit);
        int n = 0;
        while (served[0] + served[1] < target && n < limit) begin
            step(); n++;
        end
        check_eq("wait_bound", 64'(n < limit), 64'(1));
    endtask

    // Asserts reset from the current time, checks async and held reset values, releases.
    task automatic do_reset();
        nreset = 1'b0; s_ready = 0; tgt = -1;
        #1;
        check_eq("rst_async_s_valid", 64'(s_valid), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_s_valid", 64'(s_valid), 64'(0));
        check_eq("rst_s_addr", 64'(s_addr), 64'(0));
        check_eq("rst_s_wdata", 64'(s_wdata), 64'(0));
        check_eq("rst_s_wstrb", 64'(s_wstrb), 64'(0));
        check_eq("rst_m0_ready", 64'(m0_ready), 64'(0));
        check_eq("rst_m1_ready", 64'(m1_ready), 64'(0));
        check_eq("rst_rdata", 64'(m0_rdata), 64'(0));
        check_eq("rst_grant", 64'(grant), 64'(0));
        check_eq("rst_timeout", 64'(timeout), 64'(0));
        busy_m = 0; ref_last = 1; ref_to = 0; free_at = 0;
        nreset = 1'b1;
        apply();
    endtask

    initial begin
        int base;
        v[0] = 0; v[1] = 0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdata[i] = '0; wstrb[i] = '0; served[i] = 0;
        end
        s_rdata = '0; s_ready = 0;
        apply();
        do_reset();

        // m0 read of 0x000123, controller answers after 5 cycles.
        lat_mode = 5; rdata_fix_en = 1; rdata_fix = 32'h1234_5678;
        v[0] = 1; addr[0] = AW'(21'h000123); wdata[0] = '0; wstrb[0] = 4'h0;
        apply();
        wait_served(1, 40);
        check_eq("t1_grant", 64'(grant_log[grant_log.size()-1]), 64'(0));
        check_eq("t1_served_m0", 64'(served[0]), 64'(1));
        rdata_fix_en = 0;

        // Tie right after reset: m0 first, then the m1 write.
        do_reset();
        base = served[0] + served[1];
        new_req(0); wstrb[0] = 4'h0;
        v[1] = 1; addr[1] = AW'($urandom); wdata[1] = 32'hCAFE_BABE; wstrb[1] = 4'b0011;
        apply();
        wait_served(base + 2, 60);
        check_eq("t2_first", 64'(grant_log[grant_log.size()-2]), 64'(0));
        check_eq("t2_second", 64'(grant_log[grant_log.size()-1]), 64'(1));

        // Continuous requests from both ports: strict alternation over 8 transactions.
        base = served[0] + served[1];
        begin
            int s0, s1;
            s0 = served[0]; s1 = served[1];
            mst_mode = 1; budget = 6; lat_mode = 3;
            new_req(0); new_req(1); apply();
            wait_served(base + 8, 200);
            mst_mode = 2;
            for (int i = 0; i < 8; i++)
                check_eq("t3_alternate", 64'(grant_log[grant_log.size()-8+i]), 64'(i % 2));
            check_eq("t3_m0_pulses", 64'(served[0] - s0), 64'(4));
            check_eq("t3_m1_pulses", 64'(served[1] - s1), 64'(4));
        end

        // Dead controller: timeout response, then a normal transaction.
        lat_mode = 0;
        new_req(0); apply();
        wait_served(served[0] + served[1] + 1, 60);
        check_eq("t4_timeout_set", 64'(timeout), 64'(1));
        lat_mode = 4;
        new_req(0); apply();
        wait_served(served[0] + served[1] + 1, 60);
        check_eq("t4_timeout_sticky", 64'(timeout), 64'(1));

        // s_ready on the last BUSY cycle wins over the timeout.
        do_reset();
        lat_mode = int'(T);
        new_req(0); apply();
        wait_served(served[0] + served[1] + 1, 60);
        check_eq("t5_no_timeout", 64'(timeout), 64'(0));

        // Reset in the middle of BUSY, then a tie goes to m0.
        lat_mode = 0;
        new_req(1); apply();
        for (int n = 0; n < 20 && !busy_m; n++) step();
        check_eq("t6_busy", 64'(busy_m), 64'(1));
        repeat (3) step();
        new_req(0);
        #2;
        do_reset();
        lat_mode = 4;
        base = served[0] + served[1];
        wait_served(base + 2, 60);
        check_eq("t6_tie_m0", 64'(grant_log[grant_log.size()-2]), 64'(0));

        // Random traffic with random latencies, some beyond the timeout.
        lat_mode = -1; mst_mode = 0;
        repeat (3000) step();
        mst_mode = 2;
        begin
            int n = 0;
            while ((v[0] || v[1] || busy_m) && n < 500) begin
                step(); n++;
            end
            check_eq("drain_bound", 64'(n < 500), 64'(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
